// File: rtl/regfile_read_array_pkg.sv
// Shared sizes and types for the 32-entry register file (X0..X30 stored, X31 reads as zero).
package regfile_pkg;
   localparam int        NUM_REGS = 31;
   localparam logic [4:0] ZERO_REG = 5'd31;
   localparam int        ADDR_W   = 5;
   localparam int        DATA_W   = 64;

   typedef logic [ADDR_W-1:0]   reg_addr_t;
   typedef logic [NUM_REGS-1:0] reg_onehot_t;
endpackage

// File: rtl/regfile_read_array_if.sv
// Write-enable / data / read-port bundle between the decode/fetch logic and the register file.
interface regfile_read_array_if
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_W
);
   reg_onehot_t           Register;
   logic [DATA_WIDTH-1:0] WriteData;
   reg_addr_t             ReadRegister1;
   reg_addr_t             ReadRegister2;
   logic [DATA_WIDTH-1:0] ReadData1;
   logic [DATA_WIDTH-1:0] ReadData2;
   logic                  WriteErr;

   modport master (
      output Register, WriteData, ReadRegister1, ReadRegister2,
      input  ReadData1, ReadData2, WriteErr
   );

   modport slave (
      input  Register, WriteData, ReadRegister1, ReadRegister2,
      output ReadData1, ReadData2, WriteErr
   );
endinterface

// File: rtl/regfile_read_array_reg_cell.sv
// One register-file entry: a DATA_WIDTH flop with synchronous reset and write enable.
module reg_cell #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_we,
   input  logic [DATA_WIDTH-1:0] i_d,
   output logic [DATA_WIDTH-1:0] o_q
);
   logic [DATA_WIDTH-1:0] r_q;

   always_ff @(posedge clk) begin
      if (reset)
         r_q <= '0;
      else if (i_we)
         r_q <= i_d;
   end

   assign o_q = r_q;
endmodule

// File: rtl/regfile_read_array.sv
// Register file storage plus two combinational read ports; multi-hot write vectors are
// dropped and latched into a sticky WriteErr flag.
module regfile_read_array
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_W,
   parameter int BYPASS     = 1
) (
   input  logic                clk,
   input  logic                reset,
   regfile_read_array_if.slave bus
);
   logic                  w_any;
   logic                  w_multi;
   logic                  w_onehot_ok;
   reg_onehot_t           w_we;
   logic [NUM_REGS:0]     w_we_ext;
   logic [DATA_WIDTH-1:0] w_regs [0:NUM_REGS];
   logic                  w_byp1;
   logic                  w_byp2;
   logic                  r_write_err;

   // v & (v-1) clears the lowest set bit; anything left means two or more bits were set.
   assign w_any       = |bus.Register;
   assign w_multi     = |(bus.Register & (bus.Register - reg_onehot_t'(1)));
   assign w_onehot_ok = w_any & ~w_multi;
   assign w_we        = bus.Register & {NUM_REGS{w_onehot_ok & ~reset}};
   assign w_we_ext    = {1'b0, w_we};

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cell
      reg_cell #(.DATA_WIDTH(DATA_WIDTH)) u_cell (
         .clk   (clk),
         .reset (reset),
         .i_we  (w_we[gi]),
         .i_d   (bus.WriteData),
         .o_q   (w_regs[gi])
      );
   end
   assign w_regs[NUM_REGS] = '0;

   // The gated enable already excludes reset and multi-hot cycles, so it doubles as the bypass hit.
   assign w_byp1 = (BYPASS != 0) && (bus.ReadRegister1 != ZERO_REG) && w_we_ext[bus.ReadRegister1];
   assign w_byp2 = (BYPASS != 0) && (bus.ReadRegister2 != ZERO_REG) && w_we_ext[bus.ReadRegister2];

   assign bus.ReadData1 = w_byp1 ? bus.WriteData : w_regs[bus.ReadRegister1];
   assign bus.ReadData2 = w_byp2 ? bus.WriteData : w_regs[bus.ReadRegister2];

   always_ff @(posedge clk) begin
      if (reset)
         r_write_err <= 1'b0;
      else if (w_multi)
         r_write_err <= 1'b1;
   end

   assign bus.WriteErr = r_write_err;
endmodule

// File: tb/tb_regfile_read_array.sv
// Randomized and directed checks of regfile_read_array against an array-based reference model.
module tb_regfile_read_array;
   localparam int BYPASS = 1;

   logic clk = 1'b0;
   logic reset;
   int   errs = 0;
   int   nchk = 0;

   logic [63:0] mdl [31];
   bit          merr;

   regfile_read_array_if #(.DATA_WIDTH(64)) bus ();

   regfile_read_array #(.DATA_WIDTH(64), .BYPASS(BYPASS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] exp_rd(input logic [4:0] a, input logic [30:0] we,
                                          input logic [63:0] wd, input logic rst);
      if (a == 5'd31) return 64'd0;
      if (BYPASS != 0 && !rst && $countones(we) == 1 && we[int'(a)]) return wd;
      return mdl[int'(a)];
   endfunction

   // Drive one cycle, check combinational reads before the edge, then advance the model.
   task automatic cycle(input string tag, input logic [30:0] we, input logic [63:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2, input logic rst);
      bus.Register      = we;
      bus.WriteData     = wd;
      bus.ReadRegister1 = a1;
      bus.ReadRegister2 = a2;
      reset             = rst;
      #3;
      chk({tag, ".rd1"}, bus.ReadData1, exp_rd(a1, we, wd, rst));
      chk({tag, ".rd2"}, bus.ReadData2, exp_rd(a2, we, wd, rst));
      chk({tag, ".werr"}, {63'd0, bus.WriteErr}, {63'd0, merr});
      @(posedge clk);
      if (rst) begin
         foreach (mdl[i]) mdl[i] = '0;
         merr = 1'b0;
      end else if ($countones(we) == 1) begin
         foreach (mdl[i]) if (we[i]) mdl[i] = wd;
      end else if ($countones(we) >= 2) begin
         merr = 1'b1;
      end
      #1;
   endtask

   initial begin
      logic [30:0] we;
      logic [63:0] wd;
      logic [4:0]  a1, a2;
      int          k, j;

      bus.Register = '0; bus.WriteData = '0;
      bus.ReadRegister1 = '0; bus.ReadRegister2 = '0;
      reset = 1'b1;
      @(posedge clk); #1;
      foreach (mdl[i]) mdl[i] = '0;
      merr = 1'b0;

      // Reset state on every address of both ports
      for (int a = 0; a < 32; a++) cycle("reset_rd", '0, 64'hFFFF_FFFF_FFFF_FFFF, 5'(a), 5'(31 - a), 1'b0);

      // Single write, then neighbours untouched
      cycle("wr_x5", 31'h20, 64'hDEAD_BEEF_0000_0005, 5'd4, 5'd6, 1'b0);
      cycle("rd_x5", '0, '0, 5'd5, 5'd4, 1'b0);
      cycle("rd_x6", '0, '0, 5'd6, 5'd5, 1'b0);
      chk("x5_val", bus.ReadData2, 64'hDEAD_BEEF_0000_0005);

      // Same-cycle forwarding
      cycle("byp_x0", 31'h1, 64'h1234, 5'd5, 5'd0, 1'b0);
      cycle("post_x0", '0, '0, 5'd0, 5'd0, 1'b0);

      // Multi-hot is dropped and sticks the error flag
      cycle("multi", 31'h3, 64'hFFFF, 5'd0, 5'd1, 1'b0);
      for (int n = 0; n < 10; n++) begin
         k = $urandom_range(0, 30);
         cycle("legal_after_err", 31'(1) << k, {$urandom, $urandom}, 5'(k), 5'd1, 1'b0);
      end
      chk("werr_sticky", {63'd0, bus.WriteErr}, 64'd1);

      // X31 stays zero under any write
      for (int n = 0; n < 8; n++)
         cycle("x31", 31'(1) << $urandom_range(0, 30), {$urandom, $urandom}, 5'd31, 5'd31, 1'b0);

      // Reset drops a pending write
      cycle("wr_x30", 31'h4000_0000, 64'hA5A5, 5'd30, 5'd0, 1'b0);
      cycle("rst_wr_x30", 31'h4000_0000, 64'h5A5A, 5'd30, 5'd30, 1'b1);
      cycle("after_rst", '0, '0, 5'd30, 5'd1, 1'b0);
      chk("x30_cleared", bus.ReadData1, 64'd0);

      // Random mix of legal, idle, multi-hot and reset cycles
      for (int n = 0; n < 600; n++) begin
         k = $urandom_range(0, 9);
         j = $urandom_range(0, 30);
         if (k == 0) we = '0;
         else if (k == 1) begin
            we = 31'(1) << j;
            we |= 31'(1) << ((j + 1 + $urandom_range(0, 29)) % 31);
         end else we = 31'(1) << j;
         wd = {$urandom, $urandom};
         a1 = ($urandom_range(0, 1) == 0) ? 5'(j) : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
         cycle("rand", we, wd, a1, a2, ($urandom_range(0, 49) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end
endmodule
